// File: rtl/matmul_share_arbiter.sv
// matmul_share_arbiter: round-robin owner selection and start/done sequencing
// for one matmul_array shared by several attention stage controllers.
// Optional watchdog abort is built only when MM_ARB_WATCHDOG_EN is defined.
module matmul_share_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int SEL_W       = $clog2(NUM_REQ),
  parameter int WDOG_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               mm_start,
  input  logic               mm_done,
  output logic [NUM_REQ-1:0] req_done,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]   LAST_IDX  = SEL_W'(NUM_REQ - 1);

  state_t             state_r, state_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  logic [NUM_REQ-1:0] req_done_r, req_done_nxt_s;
  logic [SEL_W-1:0]   sel_r, sel_nxt_s;
  logic [SEL_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [SEL_W-1:0]   adv_ptr_s;
  logic [SEL_W-1:0]   pick_idx_s;
  logic               pick_vld_s;
  logic               mm_start_r, mm_start_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               err_r, err_nxt_s;
  logic               done_hit_s, wdog_hit_s, job_end_s;

  // First set request bit scanning upward from ptr, wrapping; MSB of result is "found".
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   ptr);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = {(SEL_W+1){1'b0}};
    // Walk from the farthest offset down so the nearest set bit is the one kept.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % NUM_REQ);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign {pick_vld_s, pick_idx_s} = rr_pick(req, rr_ptr_r);
  assign adv_ptr_s = (sel_r == LAST_IDX) ? {SEL_W{1'b0}} : sel_r + SEL_W'(1);

  // A done pulse during the start cycle is stale: the engine cannot finish in zero cycles.
  assign done_hit_s = (state_r == ST_RUN) && mm_done && !mm_start_r;
  assign job_end_s  = done_hit_s || wdog_hit_s;

`ifdef MM_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_r;

  // Counts RUN cycles of the current job; held at zero whenever no job is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
    end else begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end
  end

  // The limit edge is the one where the count would reach WDOG_CYCLES; a real done wins.
  assign wdog_hit_s = (state_r == ST_RUN) &&
                      (wdog_cnt_r == WDOG_W'(WDOG_CYCLES - 1)) && !done_hit_s;
`else
  assign wdog_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for completion in RUN, one RELEASE cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (job_end_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RELEASE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the round-robin pointer.
  always_comb begin
    grant_nxt_s    = grant_r;
    sel_nxt_s      = sel_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    mm_start_nxt_s = 1'b0;
    req_done_nxt_s = {NUM_REQ{1'b0}};
    err_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          grant_nxt_s    = ONE_HOT_0 << pick_idx_s;
          sel_nxt_s      = pick_idx_s;
          mm_start_nxt_s = 1'b1;
        end else begin
          grant_nxt_s    = {NUM_REQ{1'b0}};
        end
      end
      ST_RUN: begin
        if (job_end_s) begin
          grant_nxt_s    = {NUM_REQ{1'b0}};
          req_done_nxt_s = ONE_HOT_0 << sel_r;
          rr_ptr_nxt_s   = adv_ptr_s;
          err_nxt_s      = wdog_hit_s;
        end else begin
          grant_nxt_s    = grant_r;
        end
      end
      ST_RELEASE: grant_nxt_s = {NUM_REQ{1'b0}};
      default:    grant_nxt_s = {NUM_REQ{1'b0}};
    endcase
  end

  assign busy_nxt_s = (state_nxt_s != ST_IDLE);

  // Output and pointer registers; everything clears immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r    <= {NUM_REQ{1'b0}};
      sel_r      <= {SEL_W{1'b0}};
      rr_ptr_r   <= {SEL_W{1'b0}};
      mm_start_r <= 1'b0;
      req_done_r <= {NUM_REQ{1'b0}};
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      grant_r    <= grant_nxt_s;
      sel_r      <= sel_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      mm_start_r <= mm_start_nxt_s;
      req_done_r <= req_done_nxt_s;
      busy_r     <= busy_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign grant    = grant_r;
  assign sel      = sel_r;
  assign mm_start = mm_start_r;
  assign req_done = req_done_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule

// File: tb/tb_matmul_share_arbiter.sv
// Self-checking bench for matmul_share_arbiter (NUM_REQ=3): directed vector
// table, hand-written corner sequences, and randomized traffic against a
// job-level reference model.
`timescale 1ns/1ps
module tb_matmul_share_arbiter;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [1:0]   sel;
  logic         mm_start;
  logic         mm_done;
  logic [N-1:0] req_done;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  matmul_share_arbiter #(.NUM_REQ(N), .SEL_W(2), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .sel(sel),
    .mm_start(mm_start), .mm_done(mm_done), .req_done(req_done),
    .busy(busy), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req     = 3'b000;
    mm_done = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {grant, sel, mm_start, req_done, busy, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step();
      if (mm_start === 1'b1) seen = 1'b1;
    end
    check({name, "_start_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // lat cycles after the start cycle, pulse done; requester drops req on req_done.
  task automatic finish_job(input logic [N-1:0] exp_g, input int lat, input string name);
    for (int i = 0; i < lat; i++) step();
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    check({name, "_req_done"}, {req_done, grant}, {exp_g, 3'b000});
    req = req & ~exp_g;
    step();
    check({name, "_idle"}, {busy, req_done}, 32'd0);
  endtask

  task automatic run_job(input logic [N-1:0] exp_g, input logic [1:0] exp_s, input string name);
    wait_start(name);
    check({name, "_grant"}, {grant, sel}, {exp_g, exp_s});
    finish_job(exp_g, 2, name);
  endtask

  // ---------------- reference model (job level) ----------------
  int           m_owner;   // index of the requester owning the engine, -1 if none
  int           m_ptr;     // requester with highest priority for the next job
  int           m_sel;
  bit           m_start;
  bit           m_release;
  logic [N-1:0] m_rd;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_sel = 0; m_start = 1'b0; m_release = 1'b0; m_rd = '0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r, input logic d);
    bit           nstart;
    logic [N-1:0] nrd;
    int           idx;
    nstart = 1'b0;
    nrd    = '0;
    if (m_release) begin
      m_release = 1'b0;
    end else if (m_owner < 0) begin
      for (int off = 0; off < N; off++) begin
        idx = (m_ptr + off) % N;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_sel   = idx;
          nstart  = 1'b1;
        end
      end
    end else if (d && !m_start) begin
      nrd[m_owner] = 1'b1;
      m_ptr        = (m_owner + 1) % N;
      m_owner      = -1;
      m_release    = 1'b1;
    end
    m_start = nstart;
    m_rd    = nrd;
  endfunction

  function automatic logic [10:0] model_out();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, 2'(m_sel), m_start, m_rd, (m_owner >= 0) || m_release, 1'b0};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] g;
    logic [1:0]   s;
    logic         st;
    logic [N-1:0] rd;
    logic         b;
  } vec_t;

  function automatic vec_t mkv(input logic [N-1:0] r, input logic d, input logic [N-1:0] g,
                               input logic [1:0] s, input logic st, input logic [N-1:0] rd,
                               input logic b);
    vec_t v;
    v.req = r; v.done = d; v.g = g; v.s = s; v.st = st; v.rd = rd; v.b = b;
    return v;
  endfunction

  vec_t         tbl[$];
  logic [N-1:0] rq;
  logic         dn;
  int           cnt;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Single request: entry i applies inputs in cycle i, expects outputs of cycle i+1.
    tbl.push_back(mkv(3'b010, 1'b0, 3'b010, 2'd1, 1'b1, 3'b000, 1'b1));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mkv(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 3'b000, 1'b1));
    tbl.push_back(mkv(3'b010, 1'b1, 3'b000, 2'd1, 1'b0, 3'b010, 1'b1));
    tbl.push_back(mkv(3'b000, 1'b0, 3'b000, 2'd1, 1'b0, 3'b000, 1'b0));
    tbl.push_back(mkv(3'b000, 1'b0, 3'b000, 2'd1, 1'b0, 3'b000, 1'b0));
    // Spurious done in IDLE, in the start cycle and in RELEASE; rr_ptr is now 2.
    tbl.push_back(mkv(3'b000, 1'b1, 3'b000, 2'd1, 1'b0, 3'b000, 1'b0));
    tbl.push_back(mkv(3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000, 1'b1));
    tbl.push_back(mkv(3'b001, 1'b1, 3'b001, 2'd0, 1'b0, 3'b000, 1'b1));
    tbl.push_back(mkv(3'b001, 1'b0, 3'b001, 2'd0, 1'b0, 3'b000, 1'b1));
    tbl.push_back(mkv(3'b001, 1'b1, 3'b000, 2'd0, 1'b0, 3'b001, 1'b1));
    tbl.push_back(mkv(3'b000, 1'b1, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0));
    tbl.push_back(mkv(3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000, 1'b0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      req     = tbl[i].req;
      mm_done = tbl[i].done;
      step();
      check($sformatf("vec_%0d", i), {grant, sel, mm_start, req_done, busy, err},
            {tbl[i].g, tbl[i].s, tbl[i].st, tbl[i].rd, tbl[i].b, 1'b0});
    end

    // Round-robin with all requesters held; 001 again on reassert after the wrap.
    do_reset();
    req = 3'b111;
    run_job(3'b001, 2'd0, "rr0");
    run_job(3'b010, 2'd1, "rr1");
    run_job(3'b100, 2'd2, "rr2");
    req = 3'b111;
    run_job(3'b001, 2'd0, "rr_wrap");
    req = 3'b000;
    step();

    // Late arrivals during RUN wait; next winner is scanned from rr_ptr=1.
    do_reset();
    req = 3'b001;
    wait_start("late");
    req[2] = 1'b1;
    step();
    req[1] = 1'b1;
    step();
    check("late_no_preempt", {grant, sel}, {3'b001, 2'd0});
    finish_job(3'b001, 1, "late_first");
    run_job(3'b010, 2'd1, "late_second");
    run_job(3'b100, 2'd2, "late_third");

    // Asynchronous reset in the middle of RUN, between clock edges.
    do_reset();
    req = 3'b010;
    wait_start("arst");
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clear", {grant, sel, mm_start, req_done, busy, err}, 32'd0);
    req = 3'b100;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_regrant", {grant, sel, mm_start}, {3'b100, 2'd2, 1'b1});
    finish_job(3'b100, 1, "arst_job");

`ifdef MM_ARB_WATCHDOG_EN
    do_reset();
    req = 3'b001;
    wait_start("wd");
    for (int i = 0; i < 15; i++) step();
    check("wd_before_limit", {err, req_done, grant}, {1'b0, 3'b000, 3'b001});
    step();
    check("wd_abort", {err, req_done, grant}, {1'b1, 3'b001, 3'b000});
    req = 3'b000;
    step();
    check("wd_err_clear", {err, busy}, 32'd0);
    req = 3'b010;
    wait_start("wd_race");
    for (int i = 0; i < 15; i++) step();
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    check("wd_done_wins", {err, req_done}, {1'b0, 3'b010});
    req = 3'b000;
    step();
`else
    do_reset();
    req = 3'b001;
    wait_start("nowd");
    for (int i = 0; i < 40; i++) step();
    check("nowd_hold", {err, grant, busy}, {1'b0, 3'b001, 1'b1});
    finish_job(3'b001, 1, "nowd");
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    rq  = 3'b000;
    cnt = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (m_rd[i]) rq[i] = 1'b0;
        else if (!rq[i]) rq[i] = ($urandom_range(0, 2) == 0);
        else if (m_owner == i && !m_start && $urandom_range(0, 15) == 0) rq[i] = 1'b0;
        else rq[i] = 1'b1;
      end
      if (m_start) begin
        cnt = $urandom_range(0, 8);
        dn  = ($urandom_range(0, 3) == 0);
      end else if (m_owner >= 0) begin
        if (cnt == 0) begin
          dn = 1'b1;
        end else begin
          cnt--;
          dn = 1'b0;
        end
      end else begin
        dn = ($urandom_range(0, 3) == 0);
      end
      req     = rq;
      mm_done = dn;
      model_edge(rq, dn);
      step();
      check($sformatf("rand_cycle_%0d", cyc),
            {grant, sel, mm_start, req_done, busy, err}, model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
